// File: rtl/req_ack_responder.sv
// Responder side of a level-req / pulsed-ack handshake.
// Accepts a held request, waits a clamped programmable delay, then issues a
// single-cycle ack carrying the captured request ID. Flags an initiator that
// drops req before its ack, and counts issued acks (saturating).
module req_ack_responder #(
  parameter int ID_W      = 4,
  parameter int DLY_W     = 4,
  parameter int MAX_DELAY = 10,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [ID_W-1:0]  req_id,
  input  logic [DLY_W-1:0] delay,
  output logic             ack,
  output logic [ID_W-1:0]  ack_id,
  output logic             busy,
  output logic             proto_err,
  output logic [CNT_W-1:0] ack_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [DLY_W-1:0] MAX_D   = DLY_W'(MAX_DELAY);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_reg, state_next;
  logic [DLY_W-1:0] cnt_reg, cnt_next;
  logic [ID_W-1:0]  id_reg, id_next;
  logic             perr_next;
  logic [DLY_W-1:0] dly_clamped;

  // Clamp the requested delay so the wait never exceeds MAX_DELAY cycles.
  always_comb begin
    dly_clamped = (delay > MAX_D) ? MAX_D : delay;
  end

  // Next-state logic: wait counter runs down from d; ack state is entered on
  // the edge that ends cycle d so the ack register is high in cycle d+1.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    id_next    = id_reg;
    perr_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          id_next    = req_id;
          cnt_next   = dly_clamped;
          state_next = (dly_clamped == '0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!req) begin
          perr_next  = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == DLY_W'(1)) begin
          state_next = ACK;
        end else begin
          cnt_next = cnt_reg - DLY_W'(1);
        end
      end
      ACK: begin
        // The ack has already been issued; only the follow-up differs.
        if (!req) begin
          perr_next  = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs; outputs are derived from the next state so
  // they line up with the state they describe, with no input-to-output path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      id_reg    <= '0;
      ack       <= 1'b0;
      ack_id    <= '0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
      ack_count <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      id_reg    <= id_next;
      ack       <= (state_next == ACK);
      ack_id    <= (state_next == ACK) ? id_next : '0;
      busy      <= (state_next != IDLE);
      proto_err <= perr_next;
      if (state_next == ACK && ack_count != CNT_MAX) begin
        ack_count <= ack_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_req_ack_responder.sv
// Testbench for req_ack_responder: directed handshakes plus randomized ones,
// checked cycle by cycle against a transaction-level timing model.
module tb_req_ack_responder;

  localparam int ID_W  = 4;
  localparam int DLY_W = 4;
  localparam int MAXD  = 10;
  localparam int CNT_W = 2;
  localparam int NCYC  = 4096;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req;
  logic [ID_W-1:0]  req_id;
  logic [DLY_W-1:0] delay;
  logic             ack;
  logic [ID_W-1:0]  ack_id;
  logic             busy;
  logic             proto_err;
  logic [CNT_W-1:0] ack_count;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int model_cnt = 0;

  // Expected per-cycle events, indexed by absolute cycle number.
  bit exp_ack  [NCYC];
  int exp_id   [NCYC];
  bit exp_busy [NCYC];
  bit exp_perr [NCYC];
  bit exp_rst  [NCYC];

  req_ack_responder #(
    .ID_W(ID_W), .DLY_W(DLY_W), .MAX_DELAY(MAXD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_id(req_id), .delay(delay),
    .ack(ack), .ack_id(ack_id), .busy(busy), .proto_err(proto_err),
    .ack_count(ack_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // One cycle: compare this cycle's outputs, then drive this cycle's inputs.
  task automatic run_cycle(input bit r, input int d, input int id, input bit rn);
    int cmax;
    cmax = (1 << CNT_W) - 1;
    @(negedge clk);
    if (cyc >= NCYC) begin
      $display("FAIL cycle_budget cyc=%0d got=%0d exp=%0d", cyc, cyc, NCYC - 1);
      $fatal(1, "cycle budget exceeded");
    end
    if (exp_rst[cyc]) model_cnt = 0;
    else if (exp_ack[cyc] && model_cnt < cmax) model_cnt++;
    check_val("ack", int'(ack), int'(exp_ack[cyc]));
    check_val("ack_id", int'(ack_id), exp_ack[cyc] ? exp_id[cyc] : 0);
    check_val("busy", int'(busy), int'(exp_busy[cyc]));
    check_val("proto_err", int'(proto_err), int'(exp_perr[cyc]));
    check_val("ack_count", int'(ack_count), model_cnt);
    req    = r;
    delay  = DLY_W'(d);
    req_id = ID_W'(id);
    rst_n  = rn;
    cyc++;
  endtask

  // One handshake: req held for 'hold' cycles from acceptance, then low for
  // 'gap' cycles. Expectations follow from the protocol timing rules.
  task automatic txn(input int dly, input int id, input int hold, input int gap);
    int base, d;
    bit got_ack;
    base = cyc;
    d = (dly > MAXD) ? MAXD : dly;
    got_ack = (hold > d);
    for (int t = 1; t <= hold; t++) exp_busy[base + t] = 1'b1;
    if (got_ack) begin
      exp_ack[base + d + 1] = 1'b1;
      exp_id[base + d + 1]  = id;
    end
    if (hold <= d + 1) exp_perr[base + hold + 1] = 1'b1;
    $display("[TB] txn cyc=%0d delay=%0d id=%0d hold=%0d gap=%0d ack=%0d err=%0d",
             base, dly, id, hold, gap, got_ack, (hold <= d + 1));
    for (int t = 0; t < hold + gap; t++) begin
      run_cycle(t < hold, (t == 0) ? dly : int'($urandom_range(0, 15)),
                (t == 0) ? id : int'($urandom_range(0, 15)), 1'b1);
    end
  endtask

  initial begin
    int base;
    req = 1'b0; req_id = '0; delay = '0; rst_n = 1'b0;
    for (int i = 0; i < 3; i++) exp_rst[i] = 1'b1;
    run_cycle(0, 0, 0, 0);
    run_cycle(0, 0, 0, 0);
    run_cycle(0, 0, 0, 1);
    run_cycle(0, 0, 0, 1);

    txn(0, 5, 3, 2);    // immediate ack, non-overlapping
    txn(3, 9, 6, 1);    // ack in cycle 4
    txn(15, 3, 13, 2);  // clamped to 10, ack in cycle 11
    txn(5, 7, 2, 3);    // early drop: proto_err, no ack
    txn(2, 12, 3, 1);   // req drops in the ack cycle
    for (int i = 0; i < 5; i++) txn(1, i + 1, 3, 2);  // ack_count saturates

    // Reset in the middle of a wait discards the request.
    base = cyc;
    exp_busy[base + 1] = 1'b1;
    exp_busy[base + 2] = 1'b1;
    for (int i = 3; i < 9; i++) exp_rst[base + i] = 1'b1;
    $display("[TB] txn cyc=%0d delay=4 id=6 reset in cycle 2", base);
    run_cycle(1, 4, 6, 1);
    run_cycle(1, 4, 6, 1);
    run_cycle(0, 4, 6, 0);
    for (int i = 0; i < 6; i++) run_cycle(0, 0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      txn(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
          int'($urandom_range(1, 14)), int'($urandom_range(1, 3)));
    end
    for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
